// File: rtl/bus_arb3_pkg.sv
// Shared types for the three-requester memory bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      ID_NONE = 2'd0,
      ID_DBG  = 2'd1,
      ID_D    = 2'd2,
      ID_I    = 2'd3
   } req_id_e;

   // adr[17:16] value that decodes to no device
   localparam logic [1:0] UNMAPPED_REGION = 2'b11;

   function automatic logic is_unmapped(input logic [1:0] region);
      return region == UNMAPPED_REGION;
   endfunction

endpackage

// File: rtl/bus_arb3_if.sv
// Requester handshakes plus the shared memory bus, bundled for bus_arb3.
// slave: the arbiter's view; master: the requesters / memory map view.
interface bus_arb3_if;
   logic        cpu_en;

   logic        dbg_valid;
   logic [3:0]  dbg_wren;
   logic [31:0] dbg_adr;
   logic [31:0] dbg_wdata;
   logic        dbg_ready;
   logic        dbg_err;

   logic        d_valid;
   logic [3:0]  d_wren;
   logic [31:0] d_adr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_err;

   logic        i_valid;
   logic [31:0] i_adr;
   logic        i_ready;
   logic        i_err;

   logic [31:0] rdata;

   logic        mem_op;
   logic [31:0] mem_adr;
   logic [3:0]  mem_wren;
   logic [31:0] mem_di;
   logic [31:0] mem_do;

   modport slave (
      input  cpu_en,
      input  dbg_valid, dbg_wren, dbg_adr, dbg_wdata,
      input  d_valid, d_wren, d_adr, d_wdata,
      input  i_valid, i_adr,
      input  mem_do,
      output dbg_ready, dbg_err, d_ready, d_err, i_ready, i_err,
      output rdata,
      output mem_op, mem_adr, mem_wren, mem_di
   );

   modport master (
      output cpu_en,
      output dbg_valid, dbg_wren, dbg_adr, dbg_wdata,
      output d_valid, d_wren, d_adr, d_wdata,
      output i_valid, i_adr,
      output mem_do,
      input  dbg_ready, dbg_err, d_ready, d_err, i_ready, i_err,
      input  rdata,
      input  mem_op, mem_adr, mem_wren, mem_di
   );
endinterface

// File: rtl/bus_arb3_pick.sv
// Combinational winner select: debug > data > fetch, with fetch promoted
// over data once the starvation flag is raised.
module arb_pick
   import bus_arb_pkg::*;
(
   input  logic    dbg_valid_i,
   input  logic    d_valid_i,
   input  logic    i_valid_i,
   input  logic    cpu_en_i,
   input  req_id_e excl_i,
   input  logic    starve_i,
   output req_id_e win_o
);
   logic dbg_ok, d_ok, i_ok;

   // The requester just being acknowledged is masked out: its valid is stale
   assign dbg_ok = dbg_valid_i && (excl_i != ID_DBG);
   assign d_ok   = d_valid_i && cpu_en_i && (excl_i != ID_D);
   assign i_ok   = i_valid_i && cpu_en_i && (excl_i != ID_I);

   // Priority encode
   always_comb begin
      win_o = ID_NONE;
      if (dbg_ok)                        win_o = ID_DBG;
      else if (d_ok && !(starve_i && i_ok)) win_o = ID_D;
      else if (i_ok)                     win_o = ID_I;
   end
endmodule

// File: rtl/bus_arb3.sv
// Arbiter/sequencer for the shared memory bus: one access at a time,
// IDLE -> ACCESS (bus cycle) -> RESP (ready pulse, may chain next grant).
module bus_arb3
   import bus_arb_pkg::*;
#(
   parameter int IMAX_WAIT = 4,
   parameter bit ERR_CHECK = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   bus_arb3_if.slave  bus
);
   localparam logic [3:0] IMAX_W = 4'(IMAX_WAIT);

   state_e      state_q;
   req_id_e     win_q;
   logic        unm_q;
   logic [3:0]  wait_q, wait_d;
   logic        mem_op_q;
   logic [31:0] mem_adr_q, mem_di_q;
   logic [3:0]  mem_wren_q;
   logic        dbg_rdy_q, d_rdy_q, i_rdy_q;
   logic        dbg_err_q, d_err_q, i_err_q;

   req_id_e     pick, excl, gnt;
   logic        starve, unm_nxt;
   logic [31:0] nxt_adr, nxt_wdata;
   logic [3:0]  nxt_wren;

   assign excl   = (state_q == RESP) ? win_q : ID_NONE;
   assign starve = (wait_q == IMAX_W) && bus.i_valid;

   arb_pick u_pick (
      .dbg_valid_i (bus.dbg_valid),
      .d_valid_i   (bus.d_valid),
      .i_valid_i   (bus.i_valid),
      .cpu_en_i    (bus.cpu_en),
      .excl_i      (excl),
      .starve_i    (starve),
      .win_o       (pick)
   );

   // No grants while the bus cycle itself is in flight
   assign gnt = (state_q != ACCESS) ? pick : ID_NONE;

   // Select the winning request's fields for latching
   always_comb begin
      nxt_adr   = bus.dbg_adr;
      nxt_wren  = bus.dbg_wren;
      nxt_wdata = bus.dbg_wdata;
      case (pick)
         ID_D: begin
            nxt_adr   = bus.d_adr;
            nxt_wren  = bus.d_wren;
            nxt_wdata = bus.d_wdata;
         end
         ID_I: begin
            nxt_adr   = bus.i_adr;
            nxt_wren  = '0;
            nxt_wdata = '0;
         end
         default: ;
      endcase
   end

   assign unm_nxt = ERR_CHECK && is_unmapped(nxt_adr[17:16]);

   // Starvation counter: data grants made while a fetch is waiting
   always_comb begin
      wait_d = wait_q;
      if (!bus.i_valid || gnt == ID_I)            wait_d = '0;
      else if (gnt == ID_D && wait_q != IMAX_W)   wait_d = wait_q + 4'd1;
   end

   // Starvation counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wait_q <= '0;
      else       wait_q <= wait_d;
   end

   // Sequencer FSM with registered bus and response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         win_q      <= ID_NONE;
         unm_q      <= 1'b0;
         mem_op_q   <= 1'b0;
         mem_adr_q  <= '0;
         mem_wren_q <= '0;
         mem_di_q   <= '0;
         dbg_rdy_q  <= 1'b0;
         d_rdy_q    <= 1'b0;
         i_rdy_q    <= 1'b0;
         dbg_err_q  <= 1'b0;
         d_err_q    <= 1'b0;
         i_err_q    <= 1'b0;
      end else begin
         mem_op_q   <= 1'b0;
         mem_adr_q  <= '0;
         mem_wren_q <= '0;
         mem_di_q   <= '0;
         dbg_rdy_q  <= 1'b0;
         d_rdy_q    <= 1'b0;
         i_rdy_q    <= 1'b0;
         dbg_err_q  <= 1'b0;
         d_err_q    <= 1'b0;
         i_err_q    <= 1'b0;
         case (state_q)
            ACCESS: begin
               state_q   <= RESP;
               dbg_rdy_q <= (win_q == ID_DBG);
               d_rdy_q   <= (win_q == ID_D);
               i_rdy_q   <= (win_q == ID_I);
               dbg_err_q <= (win_q == ID_DBG) && unm_q;
               d_err_q   <= (win_q == ID_D) && unm_q;
               i_err_q   <= (win_q == ID_I) && unm_q;
            end
            default: begin
               // IDLE and RESP both arbitrate; RESP can chain straight into ACCESS
               if (gnt != ID_NONE) begin
                  state_q    <= ACCESS;
                  win_q      <= gnt;
                  unm_q      <= unm_nxt;
                  mem_op_q   <= !unm_nxt;
                  mem_adr_q  <= nxt_adr;
                  mem_wren_q <= unm_nxt ? 4'h0 : nxt_wren;
                  mem_di_q   <= nxt_wdata;
               end else begin
                  state_q <= IDLE;
                  win_q   <= ID_NONE;
                  unm_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.mem_op    = mem_op_q;
   assign bus.mem_adr   = mem_adr_q;
   assign bus.mem_wren  = mem_wren_q;
   assign bus.mem_di    = mem_di_q;
   assign bus.dbg_ready = dbg_rdy_q;
   assign bus.d_ready   = d_rdy_q;
   assign bus.i_ready   = i_rdy_q;
   assign bus.dbg_err   = dbg_err_q;
   assign bus.d_err     = d_err_q;
   assign bus.i_err     = i_err_q;
   // OR-bus data arrives during RESP; forced to 0 for unmapped accesses
   assign bus.rdata     = (state_q == RESP && !unm_q) ? bus.mem_do : 32'h0;
endmodule

// File: tb/tb_bus_arb3.sv
// Bench for bus_arb3: directed scenarios plus randomized traffic checked
// against a grant-timestamp reference model.
module tb_bus_arb3;
   localparam int IMAX = 4;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   bit   mem_prev = 1'b0;

   bus_arb3_if bus ();

   bus_arb3 #(.IMAX_WAIT(IMAX), .ERR_CHECK(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Memory map model: read data appears while mem_op is up and is held
   // through the following cycle; otherwise the OR-bus carries junk.
   always @(posedge clk) begin
      #1;
      if (bus.mem_op)     bus.mem_do = memval(bus.mem_adr);
      else if (!mem_prev) bus.mem_do = $urandom;
      mem_prev = bus.mem_op;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.cpu_en = 0;
      bus.dbg_valid = 0; bus.dbg_wren = 0; bus.dbg_adr = 0; bus.dbg_wdata = 0;
      bus.d_valid = 0;   bus.d_wren = 0;   bus.d_adr = 0;   bus.d_wdata = 0;
      bus.i_valid = 0;   bus.i_adr = 0;
   endtask

   function automatic logic [31:0] rnd_adr();
      logic [1:0]  rs;
      logic [15:0] lo;
      rs = 2'($urandom_range(0, 3));
      lo = 16'($urandom) & 16'hFFFC;
      return {14'd0, rs, lo};
   endfunction

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      repeat (3) tick();
      checks++;
      if ({bus.mem_op, bus.dbg_ready, bus.d_ready, bus.i_ready, bus.dbg_err, bus.d_err, bus.i_err} !== 7'b0)
         begin errors++; $display("FAIL reset_ctl got=%b exp=0", {bus.mem_op, bus.dbg_ready, bus.d_ready, bus.i_ready, bus.dbg_err, bus.d_err, bus.i_err}); end
      checks++;
      if ({bus.mem_adr, bus.mem_wren, bus.mem_di} !== 68'h0)
         begin errors++; $display("FAIL reset_bus adr=%h wren=%h di=%h exp=0", bus.mem_adr, bus.mem_wren, bus.mem_di); end
      checks++;
      if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
      reset = 0;
      tick();
      checks++;
      if (bus.mem_op !== 1'b0) begin errors++; $display("FAIL reset_idle mem_op=%b exp=0", bus.mem_op); end
   endtask

   task automatic test_single_read();
      bus.cpu_en = 1; bus.d_valid = 1; bus.d_adr = 32'h10; bus.d_wren = 0;
      tick();
      checks++;
      if (bus.mem_op !== 1'b1 || bus.mem_adr !== 32'h10 || bus.mem_wren !== 4'h0 || bus.d_ready !== 1'b0)
         begin errors++; $display("FAIL rd_access op=%b adr=%h wren=%h rdy=%b exp 1/00000010/0/0", bus.mem_op, bus.mem_adr, bus.mem_wren, bus.d_ready); end
      tick();
      checks++;
      if (bus.d_ready !== 1'b1 || bus.d_err !== 1'b0 || bus.mem_op !== 1'b0)
         begin errors++; $display("FAIL rd_resp rdy=%b err=%b op=%b exp 1/0/0", bus.d_ready, bus.d_err, bus.mem_op); end
      checks++;
      if (bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", bus.rdata); end
      bus.d_valid = 0;
      tick();
      checks++;
      if (bus.d_ready !== 1'b0 || bus.mem_op !== 1'b0)
         begin errors++; $display("FAIL rd_after rdy=%b op=%b exp 0/0", bus.d_ready, bus.mem_op); end
   endtask

   task automatic test_conflict();
      // {mem_op, dbg_ready, d_ready, i_ready} per cycle after the common rise
      logic [3:0] exp_tab [8] = '{4'b1000, 4'b0100, 4'b1000, 4'b0010,
                                  4'b1000, 4'b0001, 4'b0000, 4'b0000};
      logic [3:0] obs;
      bus.cpu_en = 1;
      bus.dbg_valid = 1; bus.dbg_adr = 32'h0000_0100; bus.dbg_wren = 0;
      bus.d_valid = 1;   bus.d_adr   = 32'h0001_0200; bus.d_wren   = 0;
      bus.i_valid = 1;   bus.i_adr   = 32'h0002_0300;
      for (int k = 0; k < 8; k++) begin
         tick();
         obs = {bus.mem_op, bus.dbg_ready, bus.d_ready, bus.i_ready};
         checks++;
         if (obs !== exp_tab[k]) begin errors++; $display("FAIL conflict_seq k=%0d got=%b exp=%b", k, obs, exp_tab[k]); end
         if (bus.dbg_ready) begin
            checks++;
            if (bus.rdata !== memval(32'h100)) begin errors++; $display("FAIL conflict_dbg_data got=%h exp=%h", bus.rdata, memval(32'h100)); end
            bus.dbg_valid = 0;
         end
         if (bus.d_ready) begin
            checks++;
            if (bus.rdata !== memval(32'h10200)) begin errors++; $display("FAIL conflict_d_data got=%h exp=%h", bus.rdata, memval(32'h10200)); end
            bus.d_valid = 0;
         end
         if (bus.i_ready) begin
            checks++;
            if (bus.rdata !== memval(32'h20300)) begin errors++; $display("FAIL conflict_i_data got=%h exp=%h", bus.rdata, memval(32'h20300)); end
            bus.i_valid = 0;
         end
      end
   endtask

   task automatic test_starvation();
      // Debug and data keep re-requesting; fetch stays pending throughout.
      // Expected grant order: (dbg d)x4, dbg, i -- repeating.
      int q[$];
      int exp_id;
      bus.cpu_en = 1;
      bus.dbg_valid = 1; bus.dbg_adr = 32'h0000_0040; bus.dbg_wren = 0;
      bus.d_valid = 1;   bus.d_adr   = 32'h0000_0080; bus.d_wren   = 0;
      bus.i_valid = 1;   bus.i_adr   = 32'h0002_0000;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (bus.dbg_ready) q.push_back(0);
         if (bus.d_ready)   q.push_back(1);
         if (bus.i_ready)   q.push_back(2);
      end
      idle_inputs();
      repeat (4) tick();
      checks++;
      if (q.size() < 20) begin errors++; $display("FAIL starve_count got=%0d exp>=20", q.size()); end
      for (int n = 0; n < 20 && n < q.size(); n++) begin
         exp_id = (n % 10 == 9) ? 2 : (n % 2);
         checks++;
         if (q[n] !== exp_id) begin errors++; $display("FAIL starve_order n=%0d got=%0d exp=%0d", n, q[n], exp_id); end
      end
   endtask

   task automatic test_unmapped();
      bus.cpu_en = 1; bus.d_valid = 1; bus.d_adr = 32'h0003_0000;
      bus.d_wren = 4'hF; bus.d_wdata = 32'h1234_5678;
      tick();
      checks++;
      if (bus.mem_op !== 1'b0 || bus.mem_wren !== 4'h0)
         begin errors++; $display("FAIL unm_access op=%b wren=%h exp 0/0", bus.mem_op, bus.mem_wren); end
      tick();
      checks++;
      if (bus.d_ready !== 1'b1 || bus.d_err !== 1'b1 || bus.mem_op !== 1'b0 || bus.mem_wren !== 4'h0)
         begin errors++; $display("FAIL unm_resp rdy=%b err=%b op=%b wren=%h exp 1/1/0/0", bus.d_ready, bus.d_err, bus.mem_op, bus.mem_wren); end
      checks++;
      if (bus.rdata !== 32'h0) begin errors++; $display("FAIL unm_rdata got=%h exp=0", bus.rdata); end
      idle_inputs();
      tick();
      checks++;
      if (bus.d_err !== 1'b0 || bus.d_ready !== 1'b0) begin errors++; $display("FAIL unm_after err=%b rdy=%b exp 0/0", bus.d_err, bus.d_ready); end
   endtask

   task automatic test_gating_reset();
      int ops = 0, drdy = 0, irdy = 0;
      bus.cpu_en = 0;
      bus.i_valid = 1; bus.i_adr = 32'h0002_0004;
      bus.dbg_valid = 1; bus.dbg_adr = 32'h0001_0008; bus.dbg_wren = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         ops += int'(bus.mem_op);
         irdy += int'(bus.i_ready);
         if (bus.dbg_ready) begin drdy++; bus.dbg_valid = 0; end
      end
      checks++;
      if (ops != 1 || drdy != 1 || irdy != 0)
         begin errors++; $display("FAIL gate_counts ops=%0d dbg=%0d i=%0d exp 1/1/0", ops, drdy, irdy); end
      bus.cpu_en = 1;
      tick();
      checks++;
      if (bus.mem_op !== 1'b1 || bus.mem_adr !== 32'h0002_0004)
         begin errors++; $display("FAIL gate_fetch op=%b adr=%h exp 1/00020004", bus.mem_op, bus.mem_adr); end
      reset = 1;
      #1;
      checks++;
      if ({bus.mem_op, bus.mem_adr, bus.mem_wren, bus.mem_di, bus.dbg_ready, bus.d_ready, bus.i_ready, bus.i_err} !== 73'h0)
         begin errors++; $display("FAIL async_reset op=%b adr=%h rdy=%b exp all 0", bus.mem_op, bus.mem_adr, {bus.dbg_ready, bus.d_ready, bus.i_ready}); end
      irdy = 0; ops = 0;
      repeat (2) begin tick(); irdy += int'(bus.i_ready); ops += int'(bus.mem_op); end
      bus.i_valid = 0;
      reset = 0;
      repeat (3) begin tick(); irdy += int'(bus.i_ready); ops += int'(bus.mem_op); end
      checks++;
      if (irdy != 0 || ops != 0) begin errors++; $display("FAIL reset_drop i_ready=%0d mem_op=%0d exp 0/0", irdy, ops); end
      bus.i_valid = 1;
      tick();
      checks++;
      if (bus.mem_op !== 1'b1) begin errors++; $display("FAIL reissue_op got=%b exp=1", bus.mem_op); end
      tick();
      checks++;
      if (bus.i_ready !== 1'b1 || bus.rdata !== memval(32'h0002_0004))
         begin errors++; $display("FAIL reissue_resp rdy=%b data=%h exp 1/%h", bus.i_ready, bus.rdata, memval(32'h0002_0004)); end
      idle_inputs();
      repeat (2) tick();
   endtask

   task automatic test_random();
      // Reference: a grant made at edge g puts the bus up after edge g and the
      // ready after edge g+1; arbitration reopens at edge g+2 with the last
      // winner masked, and is unrestricted from g+3 on.
      logic        v [3];
      logic [31:0] a [3];
      logic [3:0]  w [3];
      logic [31:0] wd [3];
      logic        en;
      int          g, win, wc, pick;
      bit          unm;
      logic [31:0] g_adr, g_wd, exp_rd;
      logic [3:0]  g_wren;
      logic [2:0]  exp_rdy, exp_err, got_rdy, got_err;
      bit          ok [3];
      idle_inputs();
      repeat (2) tick();
      for (int r = 0; r < 3; r++) begin v[r] = 0; a[r] = 0; w[r] = 0; wd[r] = 0; end
      en = 1; bus.cpu_en = 1;
      g = -100; win = -1; wc = 0; unm = 0;
      g_adr = 0; g_wd = 0; g_wren = 0;
      for (int e = 0; e < 2500; e++) begin
         @(posedge clk);
         pick = -1;
         if (e >= g + 2) begin
            ok[0] = v[0] && !(e == g + 2 && win == 0);
            ok[1] = v[1] && en && !(e == g + 2 && win == 1);
            ok[2] = v[2] && en && !(e == g + 2 && win == 2);
            if (ok[0])                             pick = 0;
            else if (ok[1] && !(wc == IMAX && v[2])) pick = 1;
            else if (ok[2])                        pick = 2;
         end
         if (!v[2] || pick == 2)       wc = 0;
         else if (pick == 1 && wc < IMAX) wc++;
         if (pick >= 0) begin
            g = e; win = pick;
            g_adr  = a[pick];
            g_wren = (pick == 2) ? 4'h0 : w[pick];
            g_wd   = (pick == 2) ? 32'h0 : wd[pick];
            unm    = (g_adr[17:16] == 2'b11);
         end
         @(negedge clk);
         checks++;
         if (bus.mem_op !== ((e == g) && !unm))
            begin errors++; $display("FAIL rnd_op e=%0d got=%b exp=%b", e, bus.mem_op, (e == g) && !unm); end
         if (e == g && !unm) begin
            checks++;
            if (bus.mem_adr !== g_adr || bus.mem_wren !== g_wren || bus.mem_di !== g_wd)
               begin errors++; $display("FAIL rnd_bus e=%0d adr=%h wren=%h di=%h exp %h/%h/%h", e, bus.mem_adr, bus.mem_wren, bus.mem_di, g_adr, g_wren, g_wd); end
         end else begin
            checks++;
            if (bus.mem_wren !== 4'h0) begin errors++; $display("FAIL rnd_wren_idle e=%0d got=%h exp=0", e, bus.mem_wren); end
         end
         exp_rdy = (e == g + 1) ? 3'(1 << win) : 3'b0;
         exp_err = (e == g + 1 && unm) ? 3'(1 << win) : 3'b0;
         got_rdy = {bus.i_ready, bus.d_ready, bus.dbg_ready};
         got_err = {bus.i_err, bus.d_err, bus.dbg_err};
         checks++;
         if (got_rdy !== exp_rdy || got_err !== exp_err)
            begin errors++; $display("FAIL rnd_resp e=%0d rdy=%b err=%b exp %b/%b", e, got_rdy, got_err, exp_rdy, exp_err); end
         if (e == g + 1 && (unm || g_wren == 4'h0)) begin
            exp_rd = unm ? 32'h0 : memval(g_adr);
            checks++;
            if (bus.rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata e=%0d got=%h exp=%h", e, bus.rdata, exp_rd); end
         end
         // Requesters: finish on ready, otherwise occasionally start a new request
         for (int r = 0; r < 3; r++) begin
            if (v[r] && e == g + 1 && win == r) v[r] = $urandom_range(0, 1) != 0;
            else if (v[r]) continue;
            else v[r] = $urandom_range(0, 3) == 0;
            if (v[r]) begin
               a[r]  = rnd_adr();
               w[r]  = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
               wd[r] = $urandom;
            end
         end
         if ($urandom_range(0, 63) == 0) en = !en;
         bus.cpu_en    = en;
         bus.dbg_valid = v[0]; bus.dbg_adr = a[0]; bus.dbg_wren = w[0]; bus.dbg_wdata = wd[0];
         bus.d_valid   = v[1]; bus.d_adr   = a[1]; bus.d_wren   = w[1]; bus.d_wdata   = wd[1];
         bus.i_valid   = v[2]; bus.i_adr   = a[2];
      end
      idle_inputs();
      repeat (4) tick();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_conflict();
      test_starvation();
      test_unmapped();
      test_gating_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
